stopwatch_core: RTL
===================

Name: stopwatch_core

Overview:
- Timekeeping stage directly upstream of the 4-digit display multiplexer.
- Turns the board clock into 0.1 s ticks and runs a BCD stopwatch: tenths, seconds ones, seconds tens, minutes (M:SS.T, 0:00.0 to 9:59.9).
- Takes raw start/stop, clear and lap buttons; synchronises and edge-detects them internally.
- Drives d0..d3 straight into the display multiplexer digit inputs.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 10, count rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2. Prescaler width is $clog2(DIV).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets all state.
- btn_start  input  1  raw start/stop button, asynchronous to clk.
- btn_clear  input  1  raw clear button, asynchronous.
- btn_lap  input  1  raw lap button, asynchronous; ignored unless LAP_EN.
- d0  output  4  tenths digit, BCD 0-9.
- d1  output  4  seconds ones, BCD 0-9.
- d2  output  4  seconds tens, BCD 0-5.
- d3  output  4  minutes, BCD 0-9.
- running  output  1  high while state is RUN.
- rollover  output  1  one-clk pulse on wrap from 9:59.9 to 0:00.0.
- lap_active  output  1  high while the display is frozen by lap; constant 0 without LAP_EN.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all counter and display digits 0, prescaler 0, sync/edge flops 0. Outputs: d0..d3=0, running=0, rollover=0, lap_active=0. Release is synchronous to clk.
- Button front end:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detector (third flop).
  - Press pulse is one clk wide.
  - Button first sampled high at edge k → command acts at edge k+3.
  - Holding a button produces exactly one pulse.
- FSM, with clear_p priority over start_p in the same cycle:
  - IDLE: digits 0, prescaler held at 0. start_p → RUN. clear_p → IDLE (no-op).
  - RUN: prescaler counts. start_p → PAUSE. clear_p → digits 0, prescaler 0, stay RUN.
  - PAUSE: prescaler and digits hold. start_p → RUN, prescaler resumes from its held value. clear_p → IDLE, digits 0, prescaler 0.
  - Simultaneous start_p and clear_p: clear action only; start ignored that cycle.
- Prescaler, RUN only:
  - Counts 0..DIV-1.
  - At DIV-1: wraps to 0 and issues an internal tick the same edge.
  - First tick occurs DIV clocks after entering RUN from IDLE.
- BCD chain on tick, all updates on that same edge:
  - d0 9→0 carries into d1.
  - d1 9→0 carries into d2.
  - d2 5→0 carries into d3.
  - d3 9→0 wraps; rollover=1 for exactly that clk, counting continues.
- Digit outputs are registered. They change on the tick edge, zero latency beyond the register.
- Illegal digit values are unreachable. No lookahead, no saturation.

Optional Feature:
- Macro LAP_EN.
- Defined:
  - In RUN, a lap press copies the current digits into a hold register, sets lap_active=1, and drives d0..d3 from the hold register. Internal counting continues.
  - A second lap press (any state) clears lap_active; outputs track the live count from that edge.
  - Lap press in IDLE or PAUSE with lap_active=0 is ignored.
  - clear_p forces lap_active=0 and zeros both live and held digits.
  - Reset zeros the hold register.
  - lap_p and start_p in the same cycle: both act.
- Undefined: btn_lap unused (its sync logic omitted), lap_active tied 0, d0..d3 always show the live count.

Test Plan (CLK_HZ=100, TICK_HZ=10, so DIV=10):
- Reset then btn_start high 1 clk → running=1 at edge 3 after sampling; d0=1 exactly 10 clks later; after 100 clks from RUN entry, d1=1, d0=0.
- Run to 0:59.9, next tick → d3=1, d2=0, d1=0, d0=0. Run to 9:59.9, next tick → all digits 0, rollover=1 for one clk, running stays 1.
- RUN, press start at prescaler=4 → PAUSE with digits frozen for 50 clks; press start → next tick arrives after 5 more clks in RUN.
- PAUSE at 0:03.7, press start and clear together → IDLE, digits 0, running=0. In RUN at 0:02.5, press clear → digits 0, running=1, next tick after 10 clks.
- Drive reset=0 mid-count, asynchronously between edges → all outputs 0 immediately. Reset release, start held high 200 clks → only one start command.
- LAP_EN: RUN at 0:01.2, press lap → lap_active=1, outputs hold 0:01.2 for 50 clks while count reaches 0:01.7; press lap → outputs 0:01.7. Without LAP_EN → lap pulses have no effect, lap_active=0.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: 0.1 s prescaler plus BCD stopwatch (M:SS.T, 0:00.0 to 9:59.9)
// feeding the 4-digit display multiplexer. Raw buttons are synchronised and
// edge-detected here.
//
// Optional feature: define LAP_EN to build the lap-hold display register.
// Without it btn_lap is ignored, lap_active is tied low and d0..d3 always
// show the live count.
//
// Handshake note: there is no valid/ready pair. Each button yields a one-clk
// press pulse that is consumed on the edge it is high; outputs are plain
// registered levels, and rollover is a one-clk pulse.
//
// DIV = CLK_HZ / TICK_HZ is expected to be an integer >= 2.

// Two-flop synchroniser, edge-detect flop and a registered one-clk press pulse.
// A button first sampled high at edge k produces a pulse high between edges
// k+2 and k+3, so the command takes effect at edge k+3.
module stopwatch_btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic press_q;

    // Synchronise, remember the previous level and register the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            press_q <= sync2_q & ~prev_q;
        end
    end

    assign press_o = press_q;
endmodule

module stopwatch_core #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       running,
    output logic       rollover,
    output logic       lap_active
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    // live_q[0] tenths, [1] seconds ones, [2] seconds tens, [3] minutes
    logic [3:0][3:0] live_q, live_d;
    logic            roll_q, roll_d;
    logic            tick;
    logic            start_p;
    logic            clear_p;
    logic [3:0][3:0] disp;

    stopwatch_btn_sync u_sync_start (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (btn_start),
        .press_o (start_p)
    );

    stopwatch_btn_sync u_sync_clear (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (btn_clear),
        .press_o (clear_p)
    );

    // Next-state logic: clear always wins over start in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!clear_p && start_p) state_d = ST_RUN;
            ST_RUN:   if (!clear_p && start_p) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (clear_p)      state_d = ST_IDLE;
                else if (start_p) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Prescaler and BCD chain. Counting is gated on the current state being
    // RUN, so the edge that leaves RUN for PAUSE still advances the prescaler
    // and every tick period is exactly DIV clocks spent in RUN.
    always_comb begin
        presc_d = presc_q;
        live_d  = live_q;
        roll_d  = 1'b0;
        tick    = 1'b0;
        if (clear_p || state_q == ST_IDLE) begin
            presc_d = '0;
            live_d  = '0;
        end else if (state_q == ST_RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            if (tick) begin
                if (live_q[0] == 4'd9) begin
                    live_d[0] = 4'd0;
                    if (live_q[1] == 4'd9) begin
                        live_d[1] = 4'd0;
                        if (live_q[2] == 4'd5) begin
                            live_d[2] = 4'd0;
                            if (live_q[3] == 4'd9) begin
                                live_d[3] = 4'd0;
                                roll_d    = 1'b1;
                            end else begin
                                live_d[3] = live_q[3] + 4'd1;
                            end
                        end else begin
                            live_d[2] = live_q[2] + 4'd1;
                        end
                    end else begin
                        live_d[1] = live_q[1] + 4'd1;
                    end
                end else begin
                    live_d[0] = live_q[0] + 4'd1;
                end
            end
        end
    end

    // State, prescaler, live digits and rollover pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            live_q  <= '0;
            roll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            live_q  <= live_d;
            roll_q  <= roll_d;
        end
    end

`ifdef LAP_EN
    logic            lap_p;
    logic            lap_q, lap_d;
    logic [3:0][3:0] hold_q, hold_d;

    stopwatch_btn_sync u_sync_lap (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (btn_lap),
        .press_o (lap_p)
    );

    // Lap hold: first press in RUN freezes the display, any later press
    // releases it; clear drops the hold and zeros the held digits.
    always_comb begin
        lap_d  = lap_q;
        hold_d = hold_q;
        if (clear_p) begin
            lap_d  = 1'b0;
            hold_d = '0;
        end else if (lap_p) begin
            if (lap_q) begin
                lap_d = 1'b0;
            end else if (state_q == ST_RUN) begin
                lap_d  = 1'b1;
                hold_d = live_q;
            end
        end
    end

    // Lap flag and hold register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            lap_q  <= lap_d;
            hold_q <= hold_d;
        end
    end

    assign disp       = lap_q ? hold_q : live_q;
    assign lap_active = lap_q;
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
    assign disp           = live_q;
    assign lap_active     = 1'b0;
`endif

    assign d0       = disp[0];
    assign d1       = disp[1];
    assign d2       = disp[2];
    assign d3       = disp[3];
    assign running  = (state_q == ST_RUN);
    assign rollover = roll_q;
endmodule
